button_conditioner: RTL

- Front end for the counter board's user inputs: takes one raw, bouncing, asynchronous pushbutton and produces clean control signals for the counter.
- Outputs:
  - a debounced level;
  - single-cycle press and release pulses;
  - a press-toggled enable that drives the counter's enable input directly.
- Runs on the 50 MHz board clock, upstream of the counter, alongside the 1 Hz divider.

---
 rtl/button_pkg.sv | 34 +++
 rtl/button_conditioner_sync_ff.sv | 33 +++
 rtl/button_conditioner.sv | 131 +++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared constants and elaboration-time helpers for the
// pushbutton front end.
//
// Contents:
//   BTN_PRESSED / BTN_RELEASED : normalised button encodings (1 = pressed)
//   cycles_from_ms()           : converts a duration in ms to clock cycles
//   clog2()                    : ceiling log2 for counter widths
//   raw_idle()                 : raw pin value of an unpressed button
package button_pkg;

  localparam logic BTN_PRESSED  = 1'b1;
  localparam logic BTN_RELEASED = 1'b0;

  // Integer division first so that non-kHz-multiple clocks round down
  // instead of overflowing for large CLK_HZ * ms products.
  function automatic int cycles_from_ms(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // An active-low button idles high on the pin.
  function automatic logic raw_idle(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_ff.sv
// sync_ff: multi-flop synchronizer for a single asynchronous bit.
//
// Parameters:
//   DEPTH     : number of flops in the chain (2..4)
//   RESET_VAL : value every flop takes while rst_n is low
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (last flop of the chain)
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {DEPTH{RESET_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: turns one raw, bouncing, asynchronous pushbutton into
// clean control signals for the counter board.
//
// Optional feature: define BUTTON_CONDITIONER_LONG_PRESS_EN to add the
// LONG_MS parameter and the long_press output (one-cycle pulse once the
// button has been held for LONG_MS).
//
// Parameters:
//   CLK_HZ         : clock frequency in Hz
//   DEBOUNCE_MS    : stable time required before btn_level changes
//   SYNC_STAGES    : synchronizer depth (2..4)
//   BTN_ACTIVE_LOW : 1 = raw pin reads 0 when pressed
//   LONG_MS        : hold time for long_press (optional feature only)
// Ports:
//   clk_50MHz     : system clock
//   reset         : asynchronous active-low reset
//   btn_in        : raw pushbutton, asynchronous
//   btn_level     : debounced level, 1 = pressed
//   btn_press     : one-cycle pulse on debounced press
//   btn_release   : one-cycle pulse on debounced release
//   enable_toggle : inverts on every debounced press
//   long_press    : one-cycle pulse after a long hold (optional feature only)
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int BTN_ACTIVE_LOW = 1
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  ,
  parameter int LONG_MS        = 1000
`endif
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic enable_toggle
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int DB_CYCLES = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
  localparam int DB_W      = clog2(DB_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic RAW_IDLE = raw_idle(BTN_ACTIVE_LOW != 0);

  logic            sync_raw;
  logic            s;
  logic            mismatch;
  logic            db_done;
  logic [DB_W-1:0] db_cnt;

  sync_ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (RAW_IDLE)
  ) u_sync (
    .clk   (clk_50MHz),
    .rst_n (reset),
    .d     (btn_in),
    .q     (sync_raw)
  );

  // Normalise after the synchronizer so everything downstream is 1 = pressed.
  assign s = (BTN_ACTIVE_LOW != 0) ? ~sync_raw : sync_raw;

  always_comb begin
    mismatch = (s != btn_level);
    // Counter reaches DB_LAST on the DB_CYCLES-th consecutive mismatch.
    db_done  = mismatch && (db_cnt == DB_LAST);
  end

  // Debounce counter, level, edge pulses and press toggle share one process
  // so the pulses land on the same edge that updates btn_level.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      db_cnt        <= '0;
      btn_level     <= BTN_RELEASED;
      btn_press     <= 1'b0;
      btn_release   <= 1'b0;
      enable_toggle <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (!mismatch) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt      <= '0;
        btn_level   <= s;
        btn_press   <= (s == BTN_PRESSED);
        btn_release <= (s == BTN_RELEASED);
        if (s == BTN_PRESSED) begin
          enable_toggle <= ~enable_toggle;
        end
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int LONG_CYCLES = cycles_from_ms(CLK_HZ, LONG_MS);
  localparam int LG_W        = clog2(LONG_CYCLES) + 1;
  localparam logic [LG_W-1:0] LONG_MAX  = LG_W'(LONG_CYCLES);
  localparam logic [LG_W-1:0] LONG_LAST = LG_W'(LONG_CYCLES - 1);

  logic [LG_W-1:0] hold_cnt;

  // Saturating at LONG_CYCLES means the LONG_LAST match happens only once
  // per hold; a debounced release clears the counter and re-arms it.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= btn_level && (hold_cnt == LONG_LAST);
      if (!btn_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt != LONG_MAX) begin
        hold_cnt <= hold_cnt + LG_W'(1);
      end
    end
  end
`endif

endmodule
